accm_freq_meter: RTL

//  Receive-side companion of the ACCM phase accumulator. It recovers the frequency word X

---
 rtl/accm_freq_meter.sv | 113 +++++++++++
 1 files changed

// File: rtl/accm_freq_meter.sv
// Frequency meter for the ACCM phase accumulator: counts carry pulses and meander
// rising edges over a 2**GATE_W clock gate to recover the frequency word.
//   state | meaning
//   IDLE  | waiting for start or cont
//   GATE  | sampling co_in and mx rising edges, 2**GATE_W clocks
//   DONE  | one cycle: publish counts, re-arm if cont
module accm_freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             co_in,
    input  logic             mx_in,
    output logic [CNT_W-1:0] x_est,
    output logic [CNT_W-1:0] mx_est,
    output logic             valid,
    output logic             busy,
    output logic             ovf,
    output logic             mism
);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    localparam logic [GATE_W:0]  GATE_LAST = {1'b0, {GATE_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nx;
    logic             arm;
    logic [GATE_W:0]  gate_cnt;
    logic [CNT_W-1:0] cnt_co, cnt_mx, diff;
    logic             ovf_w, mx_d, mx_rise;

    assign mx_rise = mx_in & ~mx_d;
    assign busy    = (state == GATE);
    assign diff    = (cnt_co >= cnt_mx) ? (cnt_co - cnt_mx) : (cnt_mx - cnt_co);

    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        case (state)
            IDLE: if (start || cont) begin
                state_nx = GATE;
                arm      = 1'b1;
            end
            GATE: if (gate_cnt == GATE_LAST) state_nx = DONE;
            DONE: if (cont) begin
                state_nx = GATE;
                arm      = 1'b1;
            end else begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mx_d  <= 1'b0;
        end else begin
            state <= state_nx;
            mx_d  <= mx_in;
        end
    end

    // Working counters saturate instead of wrapping; ovf_w remembers the clip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            cnt_co   <= '0;
            cnt_mx   <= '0;
            ovf_w    <= 1'b0;
        end else if (arm) begin
            gate_cnt <= '0;
            cnt_co   <= '0;
            cnt_mx   <= '0;
            ovf_w    <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            if (co_in) begin
                if (cnt_co == CNT_MAX) ovf_w  <= 1'b1;
                else                   cnt_co <= cnt_co + 1'b1;
            end
            if (mx_rise) begin
                if (cnt_mx == CNT_MAX) ovf_w  <= 1'b1;
                else                   cnt_mx <= cnt_mx + 1'b1;
            end
        end
    end

    // Results are latched while in DONE, so they reflect the full gate even when re-arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_est  <= '0;
            mx_est <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            mism   <= 1'b0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                x_est  <= cnt_co;
                mx_est <= cnt_mx;
                ovf    <= ovf_w;
                mism   <= (diff > CNT_W'(1));
            end
        end
    end

endmodule
